// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, zero-latency imem addressing and the IF/ID register.
// Define FETCH_INTR_EN to add the interrupt pending latch, handler FSM, epc and eret return.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] INTR_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        intr_req,
  input  logic        eret,
  input  logic [31:0] imem_dout,
  output logic [9:0]  imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] epc_out,
  output logic        in_isr
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4, redir_pc;
  logic        eret_acc, take;
  logic [31:0] epc_val;
  logic        unused_bits;

  assign pc_plus4  = pc_q + 32'd4;
  assign redir_pc  = {redirect_pc[31:2], 2'b00};
  assign imem_addr = pc_q[11:2];

`ifdef FETCH_INTR_EN
  typedef enum logic {S_RUN = 1'b0, S_ISR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] epc_q, epc_d;

  // eret outranks everything and blocks a same-cycle take; eret outside the handler is ignored
  assign eret_acc = eret && (state_q == S_ISR);
  assign take     = (state_q == S_RUN) && pend_q && !stall && !eret;

  always_comb begin
    pend_d  = (pend_q || intr_req) && !take;
    epc_d   = epc_q;
    state_d = state_q;
    if (eret_acc) begin
      state_d = S_RUN;
    end else if (take) begin
      epc_d   = redirect ? redir_pc : pc_q;
      state_d = S_ISR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pend_q  <= 1'b0;
      epc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      epc_q   <= epc_d;
    end
  end

  assign epc_val     = epc_q;
  assign epc_out     = epc_q;
  assign in_isr      = (state_q == S_ISR);
  assign unused_bits = ^redirect_pc[1:0];
`else
  assign eret_acc    = 1'b0;
  assign take        = 1'b0;
  assign epc_val     = 32'h0;
  assign epc_out     = 32'h0;
  assign in_isr      = 1'b0;
  assign unused_bits = ^{redirect_pc[1:0], intr_req, eret};
`endif

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (eret_acc || take || redirect) begin
      // any control transfer flushes the wrong-path word in IF/ID
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
      if (eret_acc)  pc_d = epc_val;
      else if (take) pc_d = INTR_VECTOR;
      else           pc_d = redir_pc;
    end else if (!stall) begin
      pc_d    = pc_plus4;
      instr_d = imem_dout;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit; builds with or without FETCH_INTR_EN.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] IVEC   = 32'h0000_4180;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0, intr_req = 1'b0, eret = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_dout;
  logic [9:0]  imem_addr;
  logic [31:0] if_id_instr, if_id_pc4, epc_out;
  logic        if_id_valid, in_isr;

  fetch_unit #(.RESET_PC(RST_PC), .INTR_VECTOR(IVEC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .intr_req(intr_req), .eret(eret),
    .imem_dout(imem_dout), .imem_addr(imem_addr), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .epc_out(epc_out), .in_isr(in_isr)
  );

  always #5 clk = ~clk;
  assign imem_dout = 32'hA500_0000 | {22'd0, imem_addr};

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc, instr, pc4, epc;
    logic        valid, isr;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid, m_isr, m_pend;

  task automatic m_reset();
    m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_epc = 0;
    m_valid = 0; m_isr = 0; m_pend = 0;
  endtask

  task automatic m_flush();
    m_instr = 0; m_pc4 = 0; m_valid = 0;
  endtask

  // drive one cycle at the negedge, push the model's expectation, compare after the edge
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                      input logic ir, input logic er);
    logic [31:0] a;
    logic ea, tk;
    exp_t e;
    stall = st; redirect = rd; redirect_pc = rpc; intr_req = ir; eret = er;
    chk("addr_comb", {22'd0, imem_addr}, {22'd0, m_pc[11:2]});
    a = {rpc[31:2], 2'b00};
`ifdef FETCH_INTR_EN
    ea = er && m_isr;
    tk = !m_isr && m_pend && !st && !er;
    m_pend = (m_pend || ir) && !tk;
`else
    ea = 1'b0;
    tk = 1'b0;
`endif
    if (ea) begin
      m_pc = m_epc; m_flush(); m_isr = 0;
    end else if (tk) begin
      m_epc = rd ? a : m_pc; m_pc = IVEC; m_flush(); m_isr = 1;
    end else if (rd) begin
      m_pc = a; m_flush();
    end else if (!st) begin
      m_instr = 32'hA500_0000 | {22'd0, m_pc[11:2]};
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.epc = m_epc;
    e.valid = m_valid; e.isr = m_isr;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("imem_addr", {22'd0, imem_addr}, {22'd0, e.pc[11:2]});
    chk("if_id_instr", if_id_instr, e.instr);
    chk("if_id_pc4", if_id_pc4, e.pc4);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
    chk("epc_out", epc_out, e.epc);
    chk("in_isr", {31'd0, in_isr}, {31'd0, e.isr});
    @(negedge clk);
    stall = 0; redirect = 0; intr_req = 0; eret = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, {22'd0, imem_addr}, 32'h0);
    chk({tag, "_instr"}, if_id_instr, 32'h0);
    chk({tag, "_pc4"}, if_id_pc4, 32'h0);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'h0);
    chk({tag, "_epc"}, epc_out, 32'h0);
    chk({tag, "_isr"}, {31'd0, in_isr}, 32'h0);
  endtask

  initial begin
    m_reset();
    #3;
    chk_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("rst_held");
    rst_n = 1'b1;

    // sequential fetch from reset
    step(0, 0, 0, 0, 0);
    chk("seq1_pc4", if_id_pc4, 32'h3004);
    chk("seq1_addr", {22'd0, imem_addr}, 32'h1);
    step(0, 0, 0, 0, 0);
    chk("seq2_pc4", if_id_pc4, 32'h3008);

    // stall at pc 0x3008
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("stall_addr", {22'd0, imem_addr}, 32'h2);
      chk("stall_pc4", if_id_pc4, 32'h3008);
    end
    step(0, 0, 0, 0, 0);
    chk("resume_pc4", if_id_pc4, 32'h300C);

    // redirect overrides stall and aligns the target
    step(1, 1, 32'h0000_3043, 0, 0);
    chk("redir_addr", {22'd0, imem_addr}, 32'h010);
    chk("redir_valid", {31'd0, if_id_valid}, 32'h0);
    chk("redir_instr", if_id_instr, 32'h0);

    // 32-bit wrap
    step(0, 1, 32'hFFFF_FFFE, 0, 0);
    chk("wrap_addr_hi", {22'd0, imem_addr}, 32'h3FF);
    step(0, 0, 0, 0, 0);
    chk("wrap_addr", {22'd0, imem_addr}, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'hA500_03FF);

`ifdef FETCH_INTR_EN
    step(0, 1, 32'h0000_3010, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("intr_stall1_isr", {31'd0, in_isr}, 32'h0);
    chk("intr_stall1_addr", {22'd0, imem_addr}, 32'h004);
    step(1, 0, 0, 0, 0);
    chk("intr_stall2_isr", {31'd0, in_isr}, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("take_addr", {22'd0, imem_addr}, 32'h060);
    chk("take_epc", epc_out, 32'h3010);
    chk("take_isr", {31'd0, in_isr}, 32'h1);
    chk("take_valid", {31'd0, if_id_valid}, 32'h0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("isr_pend_isr", {31'd0, in_isr}, 32'h1);
    step(0, 0, 0, 0, 1);
    chk("eret_addr", {22'd0, imem_addr}, 32'h004);
    chk("eret_isr", {31'd0, in_isr}, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("retake_addr", {22'd0, imem_addr}, 32'h060);
    chk("retake_isr", {31'd0, in_isr}, 32'h1);
    step(0, 0, 0, 0, 1);
`else
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 1);
      chk("noint_epc", epc_out, 32'h0);
      chk("noint_isr", {31'd0, in_isr}, 32'h0);
      chk("noint_valid", {31'd0, if_id_valid}, 32'h1);
    end
    chk("noint_pc4", if_id_pc4, 32'h10);
`endif

    // random mix
    for (int i = 0; i < 300; i++) begin
      logic st, rd, ir, er;
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 4) == 0);
      ir = ($urandom_range(0, 6) == 0);
`ifdef FETCH_INTR_EN
      er = m_isr && ($urandom_range(0, 3) == 0);
`else
      er = ($urandom_range(0, 2) == 0);
`endif
      step(st, rd, $urandom, ir, er);
    end

    // reset mid-handler with a request pending
    for (int i = 0; i < 5 && !m_isr; i++) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    chk("post_rst_addr", {22'd0, imem_addr}, 32'h3);
    chk("post_rst_pc4", if_id_pc4, 32'h300C);
    chk("post_rst_isr", {31'd0, in_isr}, 32'h0);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
